// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Optional SEQ_DIVIDER_EARLY_OUT_EN: dividend < divisor finishes in one cycle with quotient 0.
module seq_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_next;
  logic [DW-1:0] q;
  logic [VW-1:0] d;
  logic [VW:0]   r;
  logic [CW-1:0] cnt;
  logic [VW+1:0] step;
  logic          early;
  logic          accept;

  // Returns {quotient_bit, next_partial_remainder}; R stays below D so R[VW] is always 0.
  function automatic logic [VW+1:0] restore_step(input logic [VW:0] r_in,
                                                  input logic bit_in,
                                                  input logic [VW-1:0] d_in);
    logic [VW:0] shifted;
    logic [VW:0] t;
    shifted = {r_in[VW-1:0], bit_in};
    t = shifted - {1'b0, d_in};
    if (!t[VW])
      return {1'b1, t};
    else
      return {1'b0, shifted};
  endfunction

  assign step   = restore_step(r, q[DW-1], d);
  assign accept = (state == IDLE) && in_valid;

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  logic [DW-1:0] divisor_ext;
  assign divisor_ext = DW'(divisor);
  assign early = (dividend < divisor_ext);
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_next = ((divisor == '0) || early) ? DONE : CALC;
      end
      CALC: begin
        if (cnt == '0)
          state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q           <= '0;
      d           <= '0;
      r           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      q   <= dividend;
      d   <= divisor;
      r   <= '0;
      cnt <= CW'(DW - 1);
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend[VW-1:0];
        div_by_zero <= 1'b1;
      end else begin
        div_by_zero <= 1'b0;
        if (early) begin
          quotient  <= '0;
          remainder <= dividend[VW-1:0];
        end
      end
    end else if (state == CALC) begin
      q <= {q[DW-2:0], step[VW+1]};
      r <= step[VW:0];
      if (cnt == '0) begin
        quotient  <= {q[DW-2:0], step[VW+1]};
        remainder <= step[VW-1:0];
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (default DW=16, VW=8).
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  localparam int SMALL_EDGES = 0;
`else
  localparam int SMALL_EDGES = 16;
`endif

  seq_divider #(.DW(16), .VW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launch one operation; exp_edges counts clock edges after the accept edge until out_valid is seen.
  task automatic run_op(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                        input int exp_edges, input logic [15:0] eq, input logic [7:0] er,
                        input logic ez);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_edges);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, ez);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_out_valid_cleared"}, out_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    // Normal divide, then hold the result under backpressure.
    run_op("div_65025_255", 16'd65025, 8'd255, 16, 16'd255, 8'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        dividend = 16'd1000;
        divisor  = 8'd7;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_quotient", quotient, 255);
      chk("bp_remainder", remainder, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    handshake("bp");
    chk("bp_kept_quotient", quotient, 255);
    @(negedge clk);
    chk("bp_no_second_result", out_valid, 0);

    run_op("div_1000_7", 16'd1000, 8'd7, 16, 16'd142, 8'd6, 1'b0);
    handshake("div_1000_7");

    // Divide by zero.
    run_op("dbz_1234", 16'h1234, 8'd0, 0, 16'hFFFF, 8'h34, 1'b1);
    handshake("dbz");
    chk("dbz_kept_flag", div_by_zero, 1);

    // Reset part-way through a divide.
    @(negedge clk);
    dividend = 16'd50000;
    divisor  = 8'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("midrst_no_pulse", out_valid, 0);
    end
    run_op("div_100_9", 16'd100, 8'd9, 16, 16'd11, 8'd1, 1'b0);
    handshake("div_100_9");

    // Back-to-back with out_ready held high: exactly one out_valid cycle each.
    @(negedge clk);
    out_ready = 1'b1;
    run_op("b2b_40000_200", 16'd40000, 8'd200, 16, 16'd200, 8'd0, 1'b0);
    @(negedge clk);
    chk("b2b_first_single_pulse", out_valid, 0);
    run_op("b2b_65535_1", 16'd65535, 8'd1, 16, 16'd65535, 8'd0, 1'b0);
    @(negedge clk);
    chk("b2b_second_single_pulse", out_valid, 0);
    out_ready = 1'b0;

    // Dividend smaller than divisor.
    run_op("small_5_9", 16'd5, 8'd9, SMALL_EDGES, 16'd0, 8'd5, 1'b0);
    handshake("small");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring unsigned divider; the inverse of the team's combinational 8x8 array multiplier.
- Takes a DW-bit dividend (a multiplier product width) and a VW-bit divisor.
- Returns a DW-bit quotient and a VW-bit remainder.
- One quotient bit per clock; valid/ready handshake on input and output so it can sit behind the multiplier datapath or a pin-level wrapper.

Parameters:
- DW, 16: dividend and quotient width.
- VW, 8: divisor and remainder width; VW <= DW.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  dividend/divisor valid.
- in_ready  output  1  block can accept an operation.
- dividend  input  DW  unsigned dividend.
- divisor  input  VW  unsigned divisor.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- quotient  output  DW  unsigned quotient.
- remainder  output  VW  unsigned remainder.
- div_by_zero  output  1  result was produced with divisor == 0.

Behaviour:
- Interface decision: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; div_by_zero=0; internal counter and registers 0.
- States:
  - IDLE: in_ready=1.
  - CALC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE:
  - On an edge with in_valid=1, latch dividend into shift register Q and divisor into D.
  - Clear partial remainder R (VW+1 bits) and set counter=DW-1.
  - If divisor==0, go to DONE with quotient={DW{1}}, remainder=dividend[VW-1:0], div_by_zero=1.
  - Otherwise go to CALC with div_by_zero=0.
- CALC, each edge:
  - T = {R[VW-1:0], Q[DW-1]} - {1'b0, D}, computed in VW+1 bits.
  - If T is non-negative (MSB 0): R=T, shift 1 into Q LSB. Otherwise R={R[VW-1:0], Q[DW-1]}, shift 0 into Q LSB.
  - Q shifts left by one every iteration.
  - When counter==0, go to DONE; otherwise decrement the counter.
- Latency: accept edge E0, DW iteration edges E1..EDW; out_valid high after edge EDW (DW cycles after accept, 16 for defaults). Divide-by-zero latency is 1 cycle.
- DONE:
  - quotient=Q, remainder=R[VW-1:0]; both stable while out_valid=1.
  - On an edge with out_ready=1, go to IDLE and deassert out_valid.
  - quotient, remainder and div_by_zero keep their last values until the next result overwrites them.
- Throughput: no pipelining. in_ready returns 1 the cycle after output handshake; back-to-back operations need at least DW+2 cycles each.
- in_valid while in_ready=0: ignored; dividend and divisor are not sampled.
- Arithmetic: remainder < divisor always; quotient*divisor + remainder == dividend exactly for divisor != 0.
- Reset mid-operation (any state): immediately returns to reset values; the in-flight result is discarded and no out_valid pulse is produced.
- out_ready while out_valid=0: no effect.

Optional Feature:
- Macro: SEQ_DIVIDER_EARLY_OUT_EN.
- Defined: in IDLE, if divisor != 0 and dividend < zero-extended divisor, go directly to DONE with quotient=0, remainder=dividend[VW-1:0], div_by_zero=0. Latency is 1 cycle. The divide-by-zero check has priority.
- Undefined: such operands take the full DW-iteration path and produce the identical result with latency DW.

Test Plan:
- Normal divide: dividend=65025, divisor=255 -> after 16 cycles out_valid=1, quotient=255, remainder=0, div_by_zero=0. Also dividend=1000, divisor=7 -> quotient=142, remainder=6.
- Divide by zero: dividend=0x1234, divisor=0 -> out_valid the cycle after accept, quotient=0xFFFF, remainder=0x34, div_by_zero=1.
- Backpressure: out_ready=0 for 10 cycles after result -> quotient and remainder constant, in_ready=0; in_valid pulsed with new operands is ignored. Raise out_ready -> one handshake, in_ready=1 next cycle.
- Reset mid-operation: assert rst 5 cycles into a divide of 50000/3 -> outputs at reset values immediately. After release, 100/9 completes with quotient=11, remainder=1.
- Back-to-back with out_ready tied 1: 40000/200 then 65535/1 -> quotient=200, remainder=0; then quotient=65535, remainder=0. No lost or duplicated out_valid.
- Small dividend: dividend=5, divisor=9 -> quotient=0, remainder=5. Latency is 1 cycle with SEQ_DIVIDER_EARLY_OUT_EN defined and 16 cycles without it.
